alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter FIXED_PRIO, default 0; 0 = round-robin between requesters, 1 = requester 0 always wins a tie.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 rN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-005 rN_ready  output  1  operation of requester N accepted this cycle.
REQ-006 rN_a, rN_b  input  32  operands of requester N.
REQ-007 rN_f  input  3  ALU function of requester N: AND 000, OR 001, ADD 010, SUB 110, SLT 111.
REQ-008 rN_rvalid  output  1  registered result for requester N available.
REQ-009 rN_rready  input  1  requester N consumes its result.
REQ-010 rN_y  output  32  result; rN_zero, rN_ovf  output  1 each: zero flag, signed overflow.

Function
REQ-011 Exactly one shared ALU instance; at most one operation accepted per cycle.
REQ-012 States: IDLE (no held result), RESP (result held for owner); owner register records which requester holds the result.
REQ-013 Accept window: state IDLE, or state RESP with owner's rready=1 in the same cycle (back-to-back).
REQ-014 In an accept window, if only one valid is high, that requester is granted; rN_ready is combinational and high only for the granted requester.
REQ-015 Both valid, FIXED_PRIO=0: grant the requester not granted last; FIXED_PRIO=1: grant requester 0.
REQ-016 Accepted operation drives the ALU in the accept cycle; y, zero and ovf are registered at that edge; rN_rvalid rises the next cycle (latency 1).
REQ-017 ovf is registered as the ALU overflow only for ADD/SUB (f[1:0]=10), otherwise 0.
REQ-018 Result outputs and rvalid hold stable while rvalid=1 and rready=0; non-owner rvalid is 0.
REQ-019 RESP with rready=1 and no accept: go IDLE, rvalid falls next cycle.
REQ-020 RESP with rready=1 and accept: stay RESP, load new result and owner; rvalid stays high if owner unchanged.
REQ-021 rN_ready is 0 in RESP when owner rready=0; a waiting requester keeps valid and operands stable until ready.
REQ-022 rready of a non-owner is ignored.
REQ-023 last-grant register updates only on accept.

Reset
REQ-024 reset_n low asynchronously forces state IDLE, all rvalid 0, y 0, zero 0, ovf 0, owner 0, last-grant 1 (requester 0 wins first tie).
REQ-025 reset mid-RESP discards the held result; no rvalid after reset release until a new accept.
REQ-026 rN_ready is 0 while reset_n is low.

Structure
REQ-027 Shared package alu_arb_pkg holds the state enum, requester-id type and the five ALU function-code constants.
REQ-028 One sub-module: the existing alu (a, b, f, y, zero, overflow), instantiated once.
REQ-029 Requester-side logic written once per index via arrays/generate, not duplicated by hand.

Verification
REQ-030 r0 only: a=7, b=5, f=010 -> r0_ready same cycle, next cycle r0_rvalid=1, y=12, zero=0, ovf=0.
REQ-031 Both valid, FIXED_PRIO=0, from reset: r0 SUB 5-5 granted first (y=0, zero=1), then r1 OR 0xF0|0x0F -> y=0xFF.
REQ-032 Hold: r0 ADD 0x7FFFFFFF+1 with r0_rready=0 for 4 cycles -> y=0x80000000, ovf=1 stable all cycles, r1_ready=0 throughout.
REQ-033 Back-to-back: r0_rready=1 every cycle, 3 SLT ops (3<4, 4<3, -1<0) -> rvalid continuous, y=1,0,1.
REQ-034 FIXED_PRIO=1, both valid continuously with immediate rready -> r0 granted every accept, r1 starved.
REQ-035 reset_n low during RESP -> rvalid 0 asynchronously, y=0, next accept behaves as from reset.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared types and ALU function codes for the ALU arbiter
// Purpose: state enum, requester-id type, requester count and ALU function-code
//          constants shared by the arbiter and its testbench.
// Ports:   none (package).
package alu_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } arb_state_t;

  typedef logic req_id_t;

  localparam logic [2:0] F_AND = 3'b000;
  localparam logic [2:0] F_OR  = 3'b001;
  localparam logic [2:0] F_ADD = 3'b010;
  localparam logic [2:0] F_SUB = 3'b110;
  localparam logic [2:0] F_SLT = 3'b111;

  // Only ADD/SUB report signed overflow.
  function automatic logic is_arith(input logic [2:0] f);
    return (f[1:0] == 2'b10);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - 32-bit ALU (AND, OR, ADD, SUB, SLT)
// Purpose: combinational ALU shared by both requesters of the arbiter.
// Ports:   a, b     32-bit operands
//          f        3-bit function code
//          y        32-bit result
//          zero     y == 0
//          overflow signed overflow of the internal adder
module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  f,
  output logic [31:0] y,
  output logic        zero,
  output logic        overflow
);

  logic [31:0] w_b_eff;
  logic [31:0] w_sum;

  // f[2] turns the adder into a subtractor (a + ~b + 1); f[1:0] picks the op.
  assign w_b_eff  = f[2] ? ~b : b;
  assign w_sum    = a + w_b_eff + {31'd0, f[2]};
  assign overflow = (a[31] == w_b_eff[31]) && (w_sum[31] != a[31]);

  always_comb begin
    y = 32'd0;
    case (f[1:0])
      2'b00:   y = a & w_b_eff;
      2'b01:   y = a | w_b_eff;
      2'b10:   y = w_sum;
      // Signed less-than: sign of a-b corrected by overflow.
      default: y = {31'd0, w_sum[31] ^ overflow};
    endcase
  end

  assign zero = (y == 32'd0);

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of one shared ALU
// Purpose: accepts at most one ALU operation per cycle from two requesters,
//          registers the result and holds it for the owning requester until
//          consumed. FIXED_PRIO=0 round-robin, 1 = requester 0 wins ties.
// Ports:   clk, reset_n           clock, async active-low reset
//          rN_valid/rN_ready      operation handshake (N = 0, 1)
//          rN_a, rN_b, rN_f       operands and function code
//          rN_rvalid/rN_rready    result handshake
//          rN_y, rN_zero, rN_ovf  registered result, zero flag, signed overflow
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic [2:0]  r0_f,
  output logic        r0_rvalid,
  input  logic        r0_rready,
  output logic [31:0] r0_y,
  output logic        r0_zero,
  output logic        r0_ovf,
  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  input  logic [2:0]  r1_f,
  output logic        r1_rvalid,
  input  logic        r1_rready,
  output logic [31:0] r1_y,
  output logic        r1_zero,
  output logic        r1_ovf
);

  logic [NUM_REQ-1:0]       w_valid;
  logic [NUM_REQ-1:0]       w_rready;
  logic [NUM_REQ-1:0]       w_ready;
  logic [NUM_REQ-1:0]       w_rvalid;
  logic [NUM_REQ-1:0][31:0] w_a;
  logic [NUM_REQ-1:0][31:0] w_b;
  logic [NUM_REQ-1:0][2:0]  w_f;

  arb_state_t  r_state;
  arb_state_t  w_state_nxt;
  req_id_t     r_owner;
  req_id_t     r_last;
  req_id_t     w_gnt;
  logic        w_win;
  logic        w_accept;

  logic [31:0] w_alu_a;
  logic [31:0] w_alu_b;
  logic [2:0]  w_alu_f;
  logic [31:0] w_alu_y;
  logic        w_alu_zero;
  logic        w_alu_ovf;
  logic [31:0] r_y;
  logic        r_zero;
  logic        r_ovf;

  assign w_valid  = {r1_valid, r0_valid};
  assign w_rready = {r1_rready, r0_rready};
  assign w_a      = {r1_a, r0_a};
  assign w_b      = {r1_b, r0_b};
  assign w_f      = {r1_f, r0_f};

  // Grant, accept window and next state.
  always_comb begin
    w_gnt = 1'b0;
    if (w_valid == 2'b11) begin
      w_gnt = (FIXED_PRIO != 0) ? 1'b0 : ~r_last;
    end else if (w_valid[1]) begin
      w_gnt = 1'b1;
    end

    // A held result frees the ALU the same cycle its owner consumes it;
    // the non-owner's rready never opens the window.
    w_win    = (r_state == ST_IDLE) || ((r_state == ST_RESP) && w_rready[r_owner]);
    w_accept = w_win && (w_valid != '0);

    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = ST_RESP;
    end else if ((r_state == ST_RESP) && w_rready[r_owner]) begin
      w_state_nxt = ST_IDLE;
    end
  end

  assign w_alu_a = w_a[w_gnt];
  assign w_alu_b = w_b[w_gnt];
  assign w_alu_f = w_f[w_gnt];

  alu u_alu (
    .a        (w_alu_a),
    .b        (w_alu_b),
    .f        (w_alu_f),
    .y        (w_alu_y),
    .zero     (w_alu_zero),
    .overflow (w_alu_ovf)
  );

  // State and result registers. r_last resets to 1 so requester 0 wins
  // the first tie in round-robin mode.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_y     <= 32'd0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_owner <= w_gnt;
        r_last  <= w_gnt;
        r_y     <= w_alu_y;
        r_zero  <= w_alu_zero;
        r_ovf   <= is_arith(w_alu_f) && w_alu_ovf;
      end
    end
  end

  // Per-requester handshake outputs; ready is suppressed during reset.
  always_comb begin
    w_ready  = '0;
    w_rvalid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_ready[i]  = reset_n && w_accept && (w_gnt == req_id_t'(i));
      w_rvalid[i] = (r_state == ST_RESP) && (r_owner == req_id_t'(i));
    end
  end

  assign r0_ready  = w_ready[0];
  assign r1_ready  = w_ready[1];
  assign r0_rvalid = w_rvalid[0];
  assign r1_rvalid = w_rvalid[1];
  assign r0_y      = r_y;
  assign r1_y      = r_y;
  assign r0_zero   = r_zero;
  assign r1_zero   = r_zero;
  assign r0_ovf    = r_ovf;
  assign r1_ovf    = r_ovf;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        r0_valid, r1_valid, r0_rready, r1_rready;
  logic [31:0] r0_a, r0_b, r1_a, r1_b;
  logic [2:0]  r0_f, r1_f;

  logic        r0_ready, r1_ready, r0_rvalid, r1_rvalid;
  logic [31:0] r0_y, r1_y;
  logic        r0_zero, r1_zero, r0_ovf, r1_ovf;

  logic        p_r0_ready, p_r1_ready, p_r0_rvalid, p_r1_rvalid;
  logic [31:0] p_r0_y, p_r1_y;
  logic        p_r0_zero, p_r1_zero, p_r0_ovf, p_r1_ovf;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.FIXED_PRIO(0)) dut (
    .clk(clk), .reset_n(reset_n),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_f(r0_f),
    .r0_rvalid(r0_rvalid), .r0_rready(r0_rready), .r0_y(r0_y), .r0_zero(r0_zero), .r0_ovf(r0_ovf),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_f(r1_f),
    .r1_rvalid(r1_rvalid), .r1_rready(r1_rready), .r1_y(r1_y), .r1_zero(r1_zero), .r1_ovf(r1_ovf)
  );

  alu_arbiter #(.FIXED_PRIO(1)) dut_prio (
    .clk(clk), .reset_n(reset_n),
    .r0_valid(r0_valid), .r0_ready(p_r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_f(r0_f),
    .r0_rvalid(p_r0_rvalid), .r0_rready(r0_rready), .r0_y(p_r0_y), .r0_zero(p_r0_zero), .r0_ovf(p_r0_ovf),
    .r1_valid(r1_valid), .r1_ready(p_r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_f(r1_f),
    .r1_rvalid(p_r1_rvalid), .r1_rready(r1_rready), .r1_y(p_r1_y), .r1_zero(p_r1_zero), .r1_ovf(p_r1_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    r0_valid = 1'b0; r1_valid = 1'b0; r0_rready = 1'b0; r1_rready = 1'b0;
    r0_a = '0; r0_b = '0; r0_f = F_AND;
    r1_a = '0; r1_b = '0; r1_f = F_AND;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    #2;
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    reset_n  = 1'b0;
    r0_valid = 1'b1;
    #3;
    check("rst_r0_ready", r0_ready, 0);
    check("rst_prio_r0_ready", p_r0_ready, 0);
    check("rst_r0_rvalid", r0_rvalid, 0);
    check("rst_r1_rvalid", r1_rvalid, 0);
    check("rst_y", r0_y, 0);
    check("rst_zero_ovf", {r0_zero, r0_ovf}, 0);
    step();
    step();
    r0_valid = 1'b0;
    reset_n  = 1'b1;

    // Single requester ADD 7+5.
    r0_valid = 1'b1; r0_a = 32'd7; r0_b = 32'd5; r0_f = F_ADD;
    #1;
    check("t1_r0_ready", r0_ready, 1);
    check("t1_r1_ready", r1_ready, 0);
    step();
    r0_valid = 1'b0;
    check("t1_r0_rvalid", r0_rvalid, 1);
    check("t1_r1_rvalid", r1_rvalid, 0);
    check("t1_y", r0_y, 32'd12);
    check("t1_zero_ovf", {r0_zero, r0_ovf}, 0);
    check("t1_prio_y", p_r0_y, 32'd12);
    r0_rready = 1'b1;
    step();
    r0_rready = 1'b0;
    check("t1_rvalid_drop", r0_rvalid, 0);

    // Tie from reset: r0 SUB first, r1 OR back-to-back.
    do_reset();
    r0_valid = 1'b1; r0_a = 32'd5; r0_b = 32'd5; r0_f = F_SUB;
    r1_valid = 1'b1; r1_a = 32'hF0; r1_b = 32'h0F; r1_f = F_OR;
    #1;
    check("t2_r0_ready", r0_ready, 1);
    check("t2_r1_ready", r1_ready, 0);
    step();
    r0_valid = 1'b0;
    #1;
    check("t2_r0_rvalid", r0_rvalid, 1);
    check("t2_y", r0_y, 32'd0);
    check("t2_zero", r0_zero, 1);
    check("t2_r1_wait", r1_ready, 0);
    r0_rready = 1'b1;
    #1;
    check("t2_r1_ready_b2b", r1_ready, 1);
    step();
    r0_rready = 1'b0; r1_valid = 1'b0;
    check("t2_r1_rvalid", r1_rvalid, 1);
    check("t2_r0_rvalid_off", r0_rvalid, 0);
    check("t2_r1_y", r1_y, 32'hFF);
    check("t2_r1_zero", r1_zero, 0);
    r1_rready = 1'b1;
    step();
    r1_rready = 1'b0;

    // Overflowing ADD held for 4 cycles while r1 waits.
    r0_valid = 1'b1; r0_a = 32'h7FFF_FFFF; r0_b = 32'd1; r0_f = F_ADD;
    r1_valid = 1'b1; r1_a = 32'hFF00; r1_b = 32'h0FF0; r1_f = F_AND;
    #1;
    check("t3_r0_ready", r0_ready, 1);
    step();
    r0_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t3_hold_rvalid", r0_rvalid, 1);
      check("t3_hold_y", r0_y, 32'h8000_0000);
      check("t3_hold_ovf", r0_ovf, 1);
      check("t3_hold_r1_ready", r1_ready, 0);
      step();
    end
    r0_rready = 1'b1;
    #1;
    check("t3_r1_ready", r1_ready, 1);
    step();
    r0_rready = 1'b0; r1_valid = 1'b0;
    check("t3_r1_rvalid", r1_rvalid, 1);
    check("t3_r0_rvalid_off", r0_rvalid, 0);
    check("t3_r1_y", r1_y, 32'h0F00);
    check("t3_r1_ovf", r1_ovf, 0);
    r1_rready = 1'b1;
    step();
    r1_rready = 1'b0;

    // Back-to-back SLT with continuous rready.
    r0_rready = 1'b1;
    r0_valid = 1'b1; r0_a = 32'd3; r0_b = 32'd4; r0_f = F_SLT;
    #1;
    check("t4_ready0", r0_ready, 1);
    step();
    r0_a = 32'd4; r0_b = 32'd3;
    #1;
    check("t4_rvalid0", r0_rvalid, 1);
    check("t4_y0", r0_y, 32'd1);
    check("t4_ready1", r0_ready, 1);
    step();
    r0_a = 32'hFFFF_FFFF; r0_b = 32'd0;
    #1;
    check("t4_rvalid1", r0_rvalid, 1);
    check("t4_y1", r0_y, 32'd0);
    step();
    r0_valid = 1'b0;
    check("t4_rvalid2", r0_rvalid, 1);
    check("t4_y2", r0_y, 32'd1);
    check("t4_ovf2", r0_ovf, 0);
    step();
    check("t4_rvalid_end", r0_rvalid, 0);
    r0_rready = 1'b0;

    // Reset during RESP.
    r0_valid = 1'b1; r0_a = 32'd2; r0_b = 32'd3; r0_f = F_ADD;
    #1;
    check("t5_r0_ready", r0_ready, 1);
    step();
    r0_valid = 1'b0;
    check("t5_rvalid", r0_rvalid, 1);
    check("t5_y", r0_y, 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_async_rvalid", r0_rvalid, 0);
    check("t5_async_y", r0_y, 32'd0);
    check("t5_async_prio_rvalid", p_r0_rvalid, 0);
    step();
    reset_n = 1'b1;
    step();
    check("t5_no_rvalid", r0_rvalid, 0);
    r0_valid = 1'b1; r0_a = 32'hC; r0_b = 32'hA; r0_f = F_AND;
    r1_valid = 1'b1; r1_a = 32'd9; r1_b = 32'd2; r1_f = F_SUB;
    #1;
    check("t5_tie_r0_ready", r0_ready, 1);
    check("t5_tie_r1_ready", r1_ready, 0);
    step();
    r0_valid = 1'b0;
    check("t5_y_and", r0_y, 32'd8);
    r0_rready = 1'b1;
    step();
    r0_rready = 1'b0; r1_valid = 1'b0;
    check("t5_r1_rvalid", r1_rvalid, 1);
    check("t5_r1_y", r1_y, 32'd7);
    r1_rready = 1'b1;
    step();
    r1_rready = 1'b0;

    // Continuous tie: prio instance starves r1, round-robin alternates.
    r0_valid = 1'b1; r0_a = 32'd1; r0_b = 32'd1; r0_f = F_ADD;
    r1_valid = 1'b1; r1_a = 32'h30; r1_b = 32'h03; r1_f = F_OR;
    r0_rready = 1'b1; r1_rready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t6_prio_r0_ready", p_r0_ready, 1);
      check("t6_prio_r1_ready", p_r1_ready, 0);
      check("t6_rr_r0_ready", r0_ready, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("t6_rr_r1_ready", r1_ready, (i % 2 == 0) ? 32'd0 : 32'd1);
      step();
      check("t6_prio_rvalid", p_r0_rvalid, 1);
      check("t6_prio_y", p_r0_y, 32'd2);
      check("t6_rr_y", r0_y, (i % 2 == 0) ? 32'd2 : 32'h33);
    end
    r0_valid = 1'b0; r1_valid = 1'b0;
    step();
    check("t6_prio_idle", p_r0_rvalid, 0);
    clear_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
